kj_sync_tx: RTL
===============

# kj_sync_tx

Serial line transmitter that drives the K/J line-state interface consumed by the sync-detecting receiver under BIST (`k`, `j`, `rx_en` inputs). On a start request it emits the SYNC pattern KJKJKJKK, then an NRZI-encoded, bit-stuffed payload word (LSB first), then an SE0 end-of-packet, and returns the line to idle J. It is the transmit end of the same link and serves as a functional stimulus source for the receiver, alongside the LFSR vector path.

## Interface
- `DATA_W`, 8: payload width in bits.
- `STUFF_LEN`, 6: number of consecutive 1 bits after which a stuffed 0 is inserted.
- `EOP_LEN`, 2: SE0 cycles at end of packet.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `start`  in  1  transmit request, sampled only in IDLE.
- `data`  in  DATA_W  payload; latched on the cycle `start` is accepted.
- `busy`  out  1  high while a packet is on the line (SYNC, DATA, EOP).
- `done`  out  1  one-cycle pulse on the first IDLE cycle after EOP.
- `tx_k`  out  1  line K component.
- `tx_j`  out  1  line J component.
- `tx_en`  out  1  line-driven qualifier; connects to the receiver's `rx_en`.

## Operation
- Line symbols `{tx_k,tx_j}`: K = 10, J = 01, SE0 = 00. Idle = J with `tx_en`=0.
- FSM states: IDLE, SYNC, DATA, EOP.
- IDLE: outputs idle. If `start`=1, latch `data` into a shift register, clear the symbol counter, and go to SYNC. `start` in any other state is ignored; it is neither queued nor latched.
- SYNC: 8 cycles emitting K,J,K,J,K,J,K,K; `tx_en`=1. The NRZI reference level after SYNC is K. Go to DATA.
- DATA: one symbol per cycle, LSB first. NRZI rule: bit 0 toggles the line (K↔J); bit 1 holds it.
  - The ones counter starts at 0 on DATA entry. It increments on each 1 bit and clears on each 0 bit or stuffed bit.
  - When the ones counter reaches STUFF_LEN, the next cycle emits a stuffed toggle, the counter clears, and the shift register does not advance.
  - A stuff owed after the final payload bit is still emitted before EOP.
  - Leave DATA when all DATA_W bits are sent and no stuff is pending.
- EOP: EOP_LEN cycles of SE0 with `tx_en`=1, then IDLE with `done`=1 for that one cycle.
- Counters: symbol counter `$clog2(DATA_W)+1` bits; ones counter `$clog2(STUFF_LEN)+1` bits; no wrap within a packet.
- `RST` low at any time (mid-SYNC, DATA or EOP): state returns to IDLE immediately. The packet is abandoned and `done` is not pulsed.

## Timing
- Reset values: `busy`=0, `done`=0, `tx_k`=0, `tx_j`=1, `tx_en`=0; all outputs are registered.
- `start` is accepted at edge t. First K appears at cycle t+1, with `busy`=`tx_en`=1 from t+1.
- SYNC occupies t+1..t+8. DATA starts at t+9 and lasts DATA_W + number_of_stuffs cycles.
- EOP occupies the following EOP_LEN cycles. `busy` drops and `done` pulses on the next cycle.
- Packet length: 8 + DATA_W + stuffs + EOP_LEN cycles. For defaults with no stuffing, that is 18 busy cycles.
- `start` held high through the `done` cycle starts the next packet on the cycle after `done`. Back-to-back packets are separated by exactly one idle J cycle.

## Test plan
- Reset then idle: hold `RST`=0, then release with `start`=0 → `{tx_k,tx_j,tx_en}`=010, `busy`=0, `done`=0 steady.
- `data`=0x00: SYNC KJKJKJKK → DATA J,K,J,K,J,K,J,K → SE0,SE0 → `done` pulse. `busy` high for 18 cycles.
- `data`=0xFF: DATA K×6, stuffed J, J, J (9 cycles) → EOP. `busy` high for 19 cycles.
- `data`=0x80: DATA J,K,J,K,J,K,J,J, no stuff. Also, `start` pulsed during DATA → ignored; the current packet is unchanged and no second packet follows.
- `data`=0xFC (bits 0,0,1,1,1,1,1,1): ones run ends on the last bit → stuffed toggle emitted after bit 7, then EOP. DATA lasts 9 cycles.
- Reset mid-DATA: assert `RST`=0 on the 3rd DATA cycle → outputs go to 010 asynchronously, no `done`. After release, `start` with `data`=0x00 produces a clean full packet.

Source files
------------

// File: rtl/kj_sync_tx_if.sv
// Transmit-side bundle between a packet source and the K/J line transmitter.
// The master issues start/data; the slave (transmitter) drives status and line.
interface kj_sync_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              tx_k;
  logic              tx_j;
  logic              tx_en;

  modport master (
    output start, data,
    input  busy, done, tx_k, tx_j, tx_en
  );

  modport slave (
    input  start, data,
    output busy, done, tx_k, tx_j, tx_en
  );
endinterface

// File: rtl/kj_sync_tx.sv
// K/J line transmitter: SYNC (KJKJKJKK), NRZI bit-stuffed payload LSB first,
// SE0 end-of-packet, then back to idle J.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle J, tx_en low; accepts start and latches data
// SYNC  | emitting KJKJKJKK; leaves the NRZI reference level at K
// DATA  | one NRZI symbol per cycle, stuffed toggle after a run of ones
// EOP   | SE0 for EOP_LEN cycles, then done pulse on return to IDLE
module kj_sync_tx #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6,
  parameter int EOP_LEN   = 2
) (
  input logic           CLK,
  input logic           RST,
  kj_sync_tx_if.slave   bus
);

  // Symbol counter also indexes the 8 SYNC symbols, so it needs >= 3 bits
  // (DATA_W >= 4).
  localparam int CW = $clog2(DATA_W) + 1;
  localparam int OW = $clog2(STUFF_LEN) + 1;

  localparam logic [CW-1:0] SYNC_LAST = CW'(7);
  localparam logic [CW-1:0] DATA_END  = CW'(DATA_W);
  localparam logic [CW-1:0] EOP_END   = CW'(EOP_LEN);
  localparam logic [OW-1:0] STUFF_AT  = OW'(STUFF_LEN);

  // Bit i set means SYNC symbol i is K: K,J,K,J,K,J,K,K from index 0.
  localparam logic [7:0] SYNC_PAT = 8'hD5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     sym_cnt;
  logic [OW-1:0]     ones_cnt;
  logic              lvl;      // NRZI line level, 1 = K, 0 = J

  // Packet sequencer; every output is registered here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shreg     <= '0;
      sym_cnt   <= '0;
      ones_cnt  <= '0;
      lvl       <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.tx_k  <= 1'b0;
      bus.tx_j  <= 1'b1;
      bus.tx_en <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg     <= bus.data;
            sym_cnt   <= CW'(1);
            state     <= SYNC;
            bus.busy  <= 1'b1;
            bus.tx_en <= 1'b1;
            bus.tx_k  <= 1'b1;
            bus.tx_j  <= 1'b0;
          end else begin
            bus.busy  <= 1'b0;
            bus.tx_en <= 1'b0;
            bus.tx_k  <= 1'b0;
            bus.tx_j  <= 1'b1;
          end
        end

        SYNC: begin
          bus.tx_k <= SYNC_PAT[sym_cnt[2:0]];
          bus.tx_j <= ~SYNC_PAT[sym_cnt[2:0]];
          if (sym_cnt == SYNC_LAST) begin
            state    <= DATA;
            sym_cnt  <= '0;
            ones_cnt <= '0;
            lvl      <= 1'b1;
          end else begin
            sym_cnt <= sym_cnt + CW'(1);
          end
        end

        DATA: begin
          if (ones_cnt == STUFF_AT) begin
            // Stuffed toggle; payload does not advance.
            lvl      <= ~lvl;
            bus.tx_k <= ~lvl;
            bus.tx_j <= lvl;
            ones_cnt <= '0;
          end else if (sym_cnt != DATA_END) begin
            if (shreg[0]) begin
              bus.tx_k <= lvl;
              bus.tx_j <= ~lvl;
              ones_cnt <= ones_cnt + OW'(1);
            end else begin
              lvl      <= ~lvl;
              bus.tx_k <= ~lvl;
              bus.tx_j <= lvl;
              ones_cnt <= '0;
            end
            shreg   <= shreg >> 1;
            sym_cnt <= sym_cnt + CW'(1);
          end else begin
            // First SE0 goes out on the same edge we enter EOP.
            bus.tx_k <= 1'b0;
            bus.tx_j <= 1'b0;
            sym_cnt  <= CW'(1);
            state    <= EOP;
          end
        end

        EOP: begin
          if (sym_cnt >= EOP_END) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            bus.tx_en <= 1'b0;
            bus.tx_k  <= 1'b0;
            bus.tx_j  <= 1'b1;
            bus.done  <= 1'b1;
          end else begin
            sym_cnt <= sym_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
